// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: types and defaults shared by the UART receive FIFO and its read arbiter.
package uart_fifo_pkg;
    localparam int FIFO_DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE, POP, SETTLE, DONE} arb_state_t;
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_read_arbiter_if.sv
// fifo_read_arbiter_if: requester-side and FIFO-side signals of the receive FIFO read arbiter.
interface fifo_read_arbiter_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS = FIFO_DATA_BITS,
    parameter int NUM_REQ   = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rd_valid;
    logic [DATA_BITS-1:0] rd_data;
    logic                 fifo_empty;
    logic                 fifo_wr_rdy;
    logic                 fifo_bist;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_pop;
    modport slave (
        input  req, fifo_empty, fifo_wr_rdy, fifo_bist, fifo_data,
        output fifo_pop, gnt, rd_valid, rd_data
    );
    modport master (
        output req, fifo_empty, fifo_wr_rdy, fifo_bist, fifo_data,
        input  fifo_pop, gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/fifo_read_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching last+1, last+2, ... modulo NUM_REQ.
module rr_arbiter
    import uart_fifo_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] win,
    output logic [IW-1:0]      win_idx
);
    logic hit;
    function automatic logic [IW-1:0] wrap(input int j);
        return IW'((j >= NUM_REQ) ? j - NUM_REQ : j);
    endfunction
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        hit = 1'b0;
        win_idx = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[wrap(int'(last) + k)]) begin
                hit = 1'b1;
                win_idx = wrap(int'(last) + k);
            end
        end
        win = hit ? NUM_REQ'(1) << win_idx : '0;
    end
endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: shares the receive FIFO pop port between requesters, shaping pop
// timing to the FIFO's two-cycle qualification and returning the byte with a valid pulse.
module fifo_read_arbiter
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS = FIFO_DATA_BITS,
    parameter int NUM_REQ   = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_read_arbiter_if.slave bus
);
    localparam int IW = idx_bits(NUM_REQ);
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fifo_read_arbiter: NUM_REQ must be within 2..8");
    end
    if ($bits(bus.fifo_data) != DATA_BITS) begin : g_bad_width
        $error("fifo_read_arbiter: bus DATA_BITS does not match");
    end
    arb_state_t           state_q, state_d;
    logic                 fifo_pop_q, fifo_pop_d;
    logic                 pop_q, wr_q;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic [IW-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]   win;
    logic [IW-1:0]        win_idx;
    logic                 wr_edge, pop_eff, start;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.req),
        .last    (last_q),
        .win     (win),
        .win_idx (win_idx)
    );
    // Mirror of the FIFO's own pop qualification, so POP ends exactly when the FIFO pops.
    assign wr_edge = bus.fifo_wr_rdy & ~wr_q;
    assign pop_eff = fifo_pop_q & pop_q & ~wr_edge & ~bus.fifo_bist;
    assign start   = (state_q == IDLE) & (|bus.req) & ~bus.fifo_empty & ~bus.fifo_bist;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fifo_pop_q <= 1'b0;
            pop_q      <= 1'b0;
            wr_q       <= 1'b0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            last_q     <= IW'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            fifo_pop_q <= fifo_pop_d;
            pop_q      <= fifo_pop_q;
            wr_q       <= bus.fifo_wr_rdy;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            last_q     <= last_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? POP : IDLE;
            POP:     state_d = pop_eff ? SETTLE : POP;
            SETTLE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // Every output is registered; these are the values loaded at the next edge.
    always_comb begin
        fifo_pop_d = start | ((state_q == POP) & ~pop_eff);
        gnt_d      = (state_q == IDLE) ? (start ? win : '0) : (state_q == DONE) ? '0 : gnt_q;
        rd_valid_d = (state_q == SETTLE) ? gnt_q : '0;
        rd_data_d  = (state_q == SETTLE) ? bus.fifo_data : rd_data_q;
        last_d     = start ? win_idx : last_q;
    end
    assign bus.fifo_pop = fifo_pop_q;
    assign bus.gnt      = gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: drives the arbiter against a queue-based FIFO and a transaction-level
// model, with literal expectations for the directed scenarios and a random soak.
module tb_fifo_read_arbiter;
    localparam int N  = 3;
    localparam int DB = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fifo_read_arbiter_if #(.DATA_BITS(DB), .NUM_REQ(N)) ifc ();
    fifo_read_arbiter #(.DATA_BITS(DB), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(ifc));
    int vectors = 0;
    int miscompares = 0;
    logic [DB-1:0] q[$];
    logic [DB-1:0] ld_arr[16];
    int ld_n = 0;
    int ld_taken = 0;
    logic f_pop_old = 1'b0, f_wr_old = 1'b0, wedge, popped;
    int ph = 0;
    int owner = 0;
    int last = N - 1;
    logic m_pop = 1'b0, m_pop_old = 1'b0, m_eff;
    logic [N-1:0] m_gnt = '0, m_valid = '0;
    logic [DB-1:0] m_data = '0, m_byte = '0;
    logic chk_en = 1'b0;
    int l_pop = -1, l_gnt = -1, l_val = -1, l_dat = -1, l_cnt = -1;
    logic [DB-1:0] hb;
    function automatic int rr_pick(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
        return l;
    endfunction
    // FIFO environment plus transaction model, both advanced on the clock edge.
    always @(posedge clk) begin
        wedge = ifc.fifo_wr_rdy & ~f_wr_old;
        popped = !rst && ifc.fifo_pop && f_pop_old && !wedge && !ifc.fifo_bist && q.size() > 0;
        m_eff = m_pop && m_pop_old && !wedge && !ifc.fifo_bist;
        m_pop_old = rst ? 1'b0 : m_pop;
        if (rst) begin
            ph = 0; m_pop = 1'b0; m_gnt = '0; m_valid = '0; m_data = '0; last = N - 1;
        end else if (ph == 0) begin
            if (|ifc.req && !ifc.fifo_empty && !ifc.fifo_bist) begin
                owner = rr_pick(ifc.req, last);
                last = owner;
                m_gnt = N'(1) << owner;
                m_pop = 1'b1;
                ph = 1;
            end
        end else if (ph == 1) begin
            if (m_eff) begin
                m_pop = 1'b0;
                m_byte = (q.size() > 0) ? q[0] : '0;
                ph = 2;
            end
        end else if (ph == 2) begin
            m_data = m_byte; m_valid = m_gnt; ph = 3;
        end else begin
            m_valid = '0; m_gnt = '0; ph = 0;
        end
        if (rst) ifc.fifo_data <= '0;
        else if (popped) ifc.fifo_data <= q.pop_front();
        if (!rst && wedge && !ifc.fifo_bist) q.push_back(DB'($urandom));
        while (ld_taken < ld_n) begin
            q.push_back(ld_arr[ld_taken]);
            ld_taken++;
        end
        f_pop_old = rst ? 1'b0 : ifc.fifo_pop;
        f_wr_old = rst ? 1'b0 : ifc.fifo_wr_rdy;
        ifc.fifo_empty <= (q.size() == 0);
    end
    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", n, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("fifo_pop", 32'(ifc.fifo_pop), 32'(m_pop));
            cmp("gnt", 32'(ifc.gnt), 32'(m_gnt));
            cmp("rd_valid", 32'(ifc.rd_valid), 32'(m_valid));
            cmp("rd_data", 32'(ifc.rd_data), 32'(m_data));
            if (l_pop >= 0) cmp("lit_fifo_pop", 32'(ifc.fifo_pop), l_pop);
            if (l_gnt >= 0) cmp("lit_gnt", 32'(ifc.gnt), l_gnt);
            if (l_val >= 0) cmp("lit_rd_valid", 32'(ifc.rd_valid), l_val);
            if (l_dat >= 0) cmp("lit_rd_data", 32'(ifc.rd_data), l_dat);
            if (l_cnt >= 0) cmp("lit_fifo_count", q.size(), l_cnt);
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
        l_pop = -1; l_gnt = -1; l_val = -1; l_dat = -1; l_cnt = -1;
    endtask
    task automatic lit(input int p, input int g, input int v, input int d, input int c);
        l_pop = p; l_gnt = g; l_val = v; l_dat = d; l_cnt = c;
    endtask
    task automatic load(input logic [DB-1:0] b);
        ld_arr[ld_n] = b;
        ld_n++;
    endtask
    // Caller is in cycle 0 with req applied; returns in the rd_valid cycle.
    task automatic txn(input int who, input int d);
        step(); lit(1, 1 << who, 0, -1, -1);
        step(); lit(1, 1 << who, 0, -1, -1);
        step(); lit(0, 1 << who, 0, -1, -1);
        step(); lit(0, 1 << who, 1 << who, d, -1);
    endtask
    initial begin
        ifc.req = '0;
        ifc.fifo_wr_rdy = 1'b0;
        ifc.fifo_bist = 1'b0;
        step(); step();
        load(8'hA5);
        step();
        chk_en = 1'b1;
        lit(0, 0, 0, 0, 1);
        rst = 1'b0;
        ifc.req = 3'b001;
        txn(0, 'hA5);
        ifc.req = '0;
        step(); lit(0, 0, 0, 'hA5, 0);
        rst = 1'b1;
        step(); rst = 1'b0;
        load(8'h11); load(8'h22); load(8'h33);
        step(); lit(0, 0, 0, 0, 3);
        ifc.req = 3'b011;
        txn(0, 'h11);
        ifc.req = 3'b010;
        step(); lit(0, 0, 0, -1, 2);
        txn(1, 'h22);
        ifc.req = 3'b001;
        step(); lit(0, 0, 0, -1, 1);
        txn(0, 'h33);
        ifc.req = '0;
        step(); lit(0, 0, 0, -1, 0);
        ifc.req = 3'b001;
        repeat (5) begin step(); lit(0, 0, 0, -1, 0); end
        load(8'h3C);
        step(); lit(0, 0, 0, -1, 1);
        txn(0, 'h3C);
        ifc.req = '0;
        step(); lit(0, 0, 0, -1, 0);
        load(8'h6E);
        ifc.fifo_bist = 1'b1;
        ifc.req = 3'b010;
        repeat (5) begin step(); lit(0, 0, 0, -1, 1); end
        ifc.fifo_bist = 1'b0;
        txn(1, 'h6E);
        ifc.req = '0;
        step(); lit(0, 0, 0, -1, 0);
        load(8'h5C);
        step(); lit(0, 0, 0, -1, 1);
        ifc.req = 3'b001;
        step(); lit(1, 1, 0, -1, 1);
        step(); lit(1, 1, 0, -1, 1);
        ifc.fifo_wr_rdy = 1'b1;
        step(); lit(1, 1, 0, -1, 2);
        step(); lit(0, 1, 0, -1, 1);
        ifc.fifo_wr_rdy = 1'b0;
        step(); lit(0, 1, 1, 'h5C, 1);
        ifc.req = '0;
        step(); lit(0, 0, 0, -1, 1);
        hb = q[0];
        ifc.req = 3'b001;
        step(); lit(1, 1, 0, -1, 1);
        step(); lit(1, 1, 0, -1, 1);
        ifc.fifo_bist = 1'b1;
        repeat (3) begin step(); lit(1, 1, 0, -1, 1); end
        step(); lit(1, 1, 0, -1, 1);
        ifc.fifo_bist = 1'b0;
        step(); lit(0, 1, 0, -1, 0);
        step(); lit(0, 1, 1, int'(hb), 0);
        ifc.req = '0;
        step(); lit(0, 0, 0, -1, 0);
        load(8'h77);
        step(); lit(0, 0, 0, -1, 1);
        ifc.req = 3'b001;
        step(); lit(1, 1, 0, -1, 1);
        step(); lit(1, 1, 0, -1, 1);
        rst = 1'b1;
        step(); lit(0, 0, 0, 0, 1);
        rst = 1'b0;
        ifc.req = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom % 300 == 0);
            if ($urandom % 6 == 0) ifc.fifo_wr_rdy = ~ifc.fifo_wr_rdy;
            ifc.fifo_bist = ifc.fifo_bist ? ($urandom % 3 != 0) : ($urandom % 25 == 0);
            for (int i = 0; i < N; i++) begin
                if (ifc.rd_valid[i]) ifc.req[i] = 1'b0;
                else if (!ifc.req[i]) ifc.req[i] = ($urandom % 4 == 0);
                else if (!ifc.gnt[i] && $urandom % 10 == 0) ifc.req[i] = 1'b0;
            end
        end
        rst = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
